// File: rtl/wb_regfile.sv
// Writeback select, 32 x 32 architectural register file with two read ports and
// optional same-cycle write-through, plus a committed-write counter.
module wb_regfile #(
  parameter bit BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic        startin_n,
  input  logic        WB_reg_write,
  input  logic        WB_mem_to_reg,
  input  logic [31:0] WB_mem_data,
  input  logic [31:0] WB_alu_result,
  input  logic [4:0]  WB_reg_dst_mux_out,
  input  logic [4:0]  ID_rs_addr,
  input  logic [4:0]  ID_rt_addr,
  output logic [31:0] ID_rs_data,
  output logic [31:0] ID_rt_data,
  output logic [31:0] WB_write_data,
  output logic        WB_write_en,
  output logic [31:0] wb_count
);

  logic [31:0] r_regs [0:31];
  logic [31:0] r_wb_count;
  logic [31:0] w_write_data;
  logic        w_write_en;
  logic [4:0]  w_rd_addr [0:1];
  logic [31:0] w_rd_data [0:1];

  assign w_write_data = WB_mem_to_reg ? WB_mem_data : WB_alu_result;
  assign w_write_en   = WB_reg_write && (WB_reg_dst_mux_out != 5'd0);

  // Entry 0 is only ever cleared; the read mux hard-wires index 0 to zero anyway.
  always_ff @(posedge clk or negedge startin_n) begin
    if (!startin_n) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (w_write_en) begin
      r_regs[WB_reg_dst_mux_out] <= w_write_data;
    end
  end

  always_ff @(posedge clk or negedge startin_n) begin
    if (!startin_n) r_wb_count <= '0;
    else if (w_write_en) r_wb_count <= r_wb_count + 32'd1;
  end

  assign w_rd_addr[0] = ID_rs_addr;
  assign w_rd_addr[1] = ID_rt_addr;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
      assign w_rd_data[gi] =
        (w_rd_addr[gi] == 5'd0) ? 32'h0 :
        (BYPASS && w_write_en && (w_rd_addr[gi] == WB_reg_dst_mux_out)) ? w_write_data :
        r_regs[w_rd_addr[gi]];
    end
  endgenerate

  assign ID_rs_data    = w_rd_data[0];
  assign ID_rt_data    = w_rd_data[1];
  assign WB_write_data = w_write_data;
  assign WB_write_en   = w_write_en;
  assign wb_count      = r_wb_count;

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: one instance per BYPASS setting sharing stimulus,
// checked each cycle against an array-based model plus directed literal cases.
module tb_wb_regfile;
  logic        clk = 1'b0;
  logic        startin_n;
  logic        WB_reg_write, WB_mem_to_reg;
  logic [31:0] WB_mem_data, WB_alu_result;
  logic [4:0]  WB_reg_dst_mux_out, ID_rs_addr, ID_rt_addr;
  logic [31:0] rs1, rt1, wd1, cnt1, rs0, rt0, wd0, cnt0;
  logic        we1, we0;

  int total = 0;
  int bad = 0;
  bit cmp_on = 1'b0;

  logic [31:0] m_regs [32];
  logic [31:0] m_count;

  always #5 clk = ~clk;

  wb_regfile #(.BYPASS(1'b1)) dut_b1 (
    .clk(clk), .startin_n(startin_n), .WB_reg_write(WB_reg_write),
    .WB_mem_to_reg(WB_mem_to_reg), .WB_mem_data(WB_mem_data),
    .WB_alu_result(WB_alu_result), .WB_reg_dst_mux_out(WB_reg_dst_mux_out),
    .ID_rs_addr(ID_rs_addr), .ID_rt_addr(ID_rt_addr), .ID_rs_data(rs1),
    .ID_rt_data(rt1), .WB_write_data(wd1), .WB_write_en(we1), .wb_count(cnt1));

  wb_regfile #(.BYPASS(1'b0)) dut_b0 (
    .clk(clk), .startin_n(startin_n), .WB_reg_write(WB_reg_write),
    .WB_mem_to_reg(WB_mem_to_reg), .WB_mem_data(WB_mem_data),
    .WB_alu_result(WB_alu_result), .WB_reg_dst_mux_out(WB_reg_dst_mux_out),
    .ID_rs_addr(ID_rs_addr), .ID_rt_addr(ID_rt_addr), .ID_rs_data(rs0),
    .ID_rt_data(rt0), .WB_write_data(wd0), .WB_write_en(we0), .wb_count(cnt0));

  // Reference: commit happens when enabled and target is nonzero; reset clears all.
  always @(posedge clk or negedge startin_n) begin
    if (!startin_n) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_count = 32'h0;
    end else if (WB_reg_write && WB_reg_dst_mux_out != 5'd0) begin
      m_regs[WB_reg_dst_mux_out] = WB_mem_to_reg ? WB_mem_data : WB_alu_result;
      m_count = m_count + 32'd1;
    end
  end

  function automatic logic [31:0] exp_wd();
    return WB_mem_to_reg ? WB_mem_data : WB_alu_result;
  endfunction

  function automatic logic exp_we();
    return WB_reg_write && (WB_reg_dst_mux_out != 5'd0);
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'h0;
    if (byp && exp_we() && a == WB_reg_dst_mux_out) return exp_wd();
    return m_regs[a];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      check("rs_b1", rs1, exp_rd(ID_rs_addr, 1'b1));
      check("rt_b1", rt1, exp_rd(ID_rt_addr, 1'b1));
      check("rs_b0", rs0, exp_rd(ID_rs_addr, 1'b0));
      check("rt_b0", rt0, exp_rd(ID_rt_addr, 1'b0));
      check("wd_b1", wd1, exp_wd());
      check("wd_b0", wd0, exp_wd());
      check("we_b1", {31'h0, we1}, {31'h0, exp_we()});
      check("we_b0", {31'h0, we0}, {31'h0, exp_we()});
      check("cnt_b1", cnt1, m_count);
      check("cnt_b0", cnt0, m_count);
    end
  end

  task automatic drive(input logic we, input logic m2r, input logic [31:0] mem,
                       input logic [31:0] alu, input logic [4:0] dst,
                       input logic [4:0] rs, input logic [4:0] rt);
    WB_reg_write = we; WB_mem_to_reg = m2r; WB_mem_data = mem;
    WB_alu_result = alu; WB_reg_dst_mux_out = dst; ID_rs_addr = rs; ID_rt_addr = rt;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    startin_n = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    repeat (2) @(posedge clk);
    #2;
    for (int i = 0; i < 32; i++) begin
      ID_rs_addr = 5'(i);
      ID_rt_addr = 5'(31 - i);
      #1;
      check($sformatf("rst_rs%0d", i), rs1 | rs0, 32'h0);
      check($sformatf("rst_rt%0d", i), rt1 | rt0, 32'h0);
    end
    check("rst_cnt", cnt1 | cnt0, 32'h0);
    next_cycle();
    startin_n = 1'b1;
    cmp_on = 1'b1;

    next_cycle(); drive(1'b1, 1'b0, 32'h0BAD0BAD, 32'hDEADBEEF, 5'd5, 5'd0, 5'd0);
    next_cycle(); drive(1'b1, 1'b1, 32'h12345678, 32'h55555555, 5'd6, 5'd0, 5'd0);
    next_cycle(); drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd6);
    @(negedge clk);
    check("lit_r5", rs0, 32'hDEADBEEF);
    check("lit_r6", rt0, 32'h12345678);
    check("lit_cnt2", cnt0, 32'd2);

    next_cycle(); drive(1'b1, 1'b0, 32'h0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    check("lit_r0_we", {31'h0, we1}, 32'h0);
    check("lit_r0_rd", rs1, 32'h0);
    next_cycle(); drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    check("lit_r0_cnt", cnt1, 32'd2);

    next_cycle(); drive(1'b1, 1'b0, 32'h0, 32'h1, 5'd7, 5'd0, 5'd0);
    next_cycle(); drive(1'b1, 1'b1, 32'hA5A5A5A5, 32'h0, 5'd7, 5'd7, 5'd7);
    @(negedge clk);
    check("lit_byp1_rs", rs1, 32'hA5A5A5A5);
    check("lit_byp1_rt", rt1, 32'hA5A5A5A5);
    check("lit_byp0_rs", rs0, 32'h1);
    check("lit_byp0_rt", rt0, 32'h1);
    next_cycle(); drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd7);
    @(negedge clk);
    check("lit_r7_after", rs0, 32'hA5A5A5A5);

    next_cycle(); drive(1'b0, 1'b0, 32'h0, 32'h0000CAFE, 5'd9, 5'd9, 5'd9);
    next_cycle(); drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd0);
    @(negedge clk);
    check("lit_r9", rs0 | rs1, 32'h0);
    check("lit_cnt4", cnt0, 32'd4);

    for (int n = 0; n < 400; n++) begin
      logic [4:0] dst;
      next_cycle();
      dst = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom), $urandom, $urandom, dst,
            ($urandom_range(0, 2) == 0) ? dst : 5'($urandom),
            ($urandom_range(0, 2) == 0) ? dst : 5'($urandom));
    end

    next_cycle(); drive(1'b1, 1'b0, 32'h0, 32'h00000077, 5'd3, 5'd3, 5'd3);
    #2;
    startin_n = 1'b0;
    #1;
    check("mid_rst_cnt_b1", cnt1, 32'h0);
    check("mid_rst_cnt_b0", cnt0, 32'h0);
    check("mid_rst_r3_b0", rs0, 32'h0);
    check("mid_rst_r3_byp", rs1, 32'h00000077);
    next_cycle(); drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd3);
    @(negedge clk);
    check("rst_r3_b1", rs1, 32'h0);
    check("rst_r3_b0", rt0, 32'h0);
    next_cycle();
    startin_n = 1'b1;
    repeat (3) next_cycle();
    @(negedge clk);
    check("post_rst_cnt", cnt1, 32'h0);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
